// File: rtl/de1_soc_demo_pll_seq_pkg.sv
// Shared types and constants for the DE1-SoC demo PLL reset sequencer.
package de1_soc_demo_pll_seq_pkg;

    typedef enum logic [2:0] {
        StResetPll = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StRelease  = 3'd3,
        StRun      = 3'd4,
        StFault    = 3'd5
    } seq_state_e;

    localparam int unsigned LOSS_CNT_W = 8;

endpackage

// File: rtl/de1_soc_demo_sync2.sv
// Two-flop synchronizer for a single asynchronous level, reset to 0.
module de1_soc_demo_sync2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/de1_soc_demo_pll_reset_seq.sv
// PLL reset pulse, lock qualification, retry/fault handling and staggered domain release.
// Define PLL_SEQ_STATUS_EN to enable the lock-loss counter and state status outputs.
module de1_soc_demo_pll_reset_seq
    import de1_soc_demo_pll_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES    = 20,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned NUM_DOMAINS         = 3,
    parameter int unsigned DOMAIN_STAGGER      = 16
) (
    input  logic                   refclk_i,
    input  logic                   rst_i,
    input  logic                   sw_reset_req_i,
    input  logic                   pll_locked_i,
    output logic                   pll_rst_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   ready_o,
    output logic                   fault_o,
    output logic [LOSS_CNT_W-1:0]  lock_loss_cnt_o,
    output logic [2:0]             seq_state_o
);

    localparam int unsigned PulseW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int unsigned StabW  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int unsigned TmoW   = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int unsigned RetryW = $clog2(MAX_RETRIES + 1);
    localparam int unsigned RelMax = (NUM_DOMAINS - 1) * DOMAIN_STAGGER;
    localparam int unsigned RelW   = (RelMax > 0) ? $clog2(RelMax + 1) : 1;

    seq_state_e                 state_q, state_d;
    logic [PulseW-1:0]          pulse_q, pulse_d;
    logic [StabW-1:0]           stab_q, stab_d;
    logic [TmoW-1:0]            tmo_q, tmo_d;
    logic [RetryW-1:0]          retry_q, retry_d;
    logic [RelW-1:0]            rel_q, rel_d;
    logic                       pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0]     domain_rst_q, domain_rst_d;
    logic                       ready_q, ready_d;
    logic                       fault_q, fault_d;
    logic                       lock_s;
    logic                       lock_lost;

    de1_soc_demo_sync2 u_lock_sync (
        .clk_i (refclk_i),
        .rst_i (rst_i),
        .d_i   (pll_locked_i),
        .q_o   (lock_s)
    );

    assign lock_lost = !lock_s && (state_q == StRelease || state_q == StRun);

    always_comb begin
        state_d = state_q;
        pulse_d = pulse_q;
        stab_d  = stab_q;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        rel_d   = rel_q;

        if (sw_reset_req_i || lock_lost) begin
            state_d = StResetPll;
            pulse_d = '0;
            retry_d = '0;
        end else if ((state_q == StWaitLock || state_q == StStable) &&
                     tmo_q == TmoW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            // Timeout wins over a STABLE->RELEASE completion in the same cycle.
            retry_d = retry_q + RetryW'(1);
            pulse_d = '0;
            state_d = (retry_d == RetryW'(MAX_RETRIES)) ? StFault : StResetPll;
        end else begin
            unique case (state_q)
                StResetPll: begin
                    if (pulse_q == PulseW'(RST_PULSE_CYCLES - 1)) begin
                        state_d = StWaitLock;
                        tmo_d   = '0;
                    end else begin
                        pulse_d = pulse_q + PulseW'(1);
                    end
                end
                StWaitLock: begin
                    tmo_d = tmo_q + TmoW'(1);
                    if (lock_s) begin
                        state_d = StStable;
                        stab_d  = '0;
                    end
                end
                StStable: begin
                    tmo_d = tmo_q + TmoW'(1);
                    if (!lock_s) begin
                        state_d = StWaitLock;
                    end else if (stab_q == StabW'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = StRelease;
                        rel_d   = '0;
                    end else begin
                        stab_d = stab_q + StabW'(1);
                    end
                end
                StRelease: begin
                    if (rel_q == RelW'(RelMax)) begin
                        state_d = StRun;
                        retry_d = '0;
                    end else begin
                        rel_d = rel_q + RelW'(1);
                    end
                end
                StRun, StFault: ;
                default: state_d = StResetPll;
            endcase
        end

        // Outputs are registered copies decoded from the next state.
        pll_rst_d    = (state_d == StResetPll) || (state_d == StFault);
        ready_d      = (state_d == StRun);
        fault_d      = (state_d == StFault);
        domain_rst_d = '1;
        for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
            if (state_d == StRun ||
                (state_d == StRelease && 32'(rel_d) >= i * DOMAIN_STAGGER)) begin
                domain_rst_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q      <= StResetPll;
            pulse_q      <= '0;
            stab_q       <= '0;
            tmo_q        <= '0;
            retry_q      <= '0;
            rel_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pulse_q      <= pulse_d;
            stab_q       <= stab_d;
            tmo_q        <= tmo_d;
            retry_q      <= retry_d;
            rel_q        <= rel_d;
            pll_rst_q    <= pll_rst_d;
            domain_rst_q <= domain_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_rst_o    = pll_rst_q;
    assign domain_rst_o = domain_rst_q;
    assign ready_o      = ready_q;
    assign fault_o      = fault_q;

`ifdef PLL_SEQ_STATUS_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;

    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            loss_cnt_q <= '0;
        end else if (lock_lost && !sw_reset_req_i && loss_cnt_q != '1) begin
            loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign lock_loss_cnt_o = loss_cnt_q;
    assign seq_state_o     = state_q;
`else
    assign lock_loss_cnt_o = '0;
    assign seq_state_o     = '0;
`endif

endmodule

// File: tb/tb_de1_soc_demo_pll_reset_seq.sv
// Self-checking bench for the PLL reset sequencer: directed scenarios plus random lock activity
// checked every cycle against a phase/elapsed-time model of the sequencing rules.
module tb_de1_soc_demo_pll_reset_seq;

    localparam int P_PULSE  = 4;
    localparam int P_STABLE = 8;
    localparam int P_TMO    = 32;
    localparam int P_RETRY  = 2;
    localparam int P_N      = 3;
    localparam int P_STG    = 2;

    localparam int PH_RESET   = 0;
    localparam int PH_WAIT    = 1;
    localparam int PH_STABLE  = 2;
    localparam int PH_RELEASE = 3;
    localparam int PH_RUN     = 4;
    localparam int PH_FAULT   = 5;

`ifdef PLL_SEQ_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sw = 1'b0;
    logic       locked = 1'b0;
    logic       pll_rst_o;
    logic [2:0] domain_rst_o;
    logic       ready_o;
    logic       fault_o;
    logic [7:0] lock_loss_cnt_o;
    logic [2:0] seq_state_o;

    always #5 clk = ~clk;

    de1_soc_demo_pll_reset_seq #(
        .RST_PULSE_CYCLES    (P_PULSE),
        .LOCK_STABLE_CYCLES  (P_STABLE),
        .LOCK_TIMEOUT_CYCLES (P_TMO),
        .MAX_RETRIES         (P_RETRY),
        .NUM_DOMAINS         (P_N),
        .DOMAIN_STAGGER      (P_STG)
    ) dut (
        .refclk_i        (clk),
        .rst_i           (rst),
        .sw_reset_req_i  (sw),
        .pll_locked_i    (locked),
        .pll_rst_o       (pll_rst_o),
        .domain_rst_o    (domain_rst_o),
        .ready_o         (ready_o),
        .fault_o         (fault_o),
        .lock_loss_cnt_o (lock_loss_cnt_o),
        .seq_state_o     (seq_state_o)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Model: phase, cycles spent in the phase, cycles spent waiting for lock since the last
    // PLL reset, retries, lock losses and the two synchronizer stages.
    int   m_phase = PH_RESET;
    int   m_t     = 0;
    int   m_wait  = 0;
    int   m_retry = 0;
    int   m_loss  = 0;
    logic m_s1    = 1'b0;
    logic m_s2    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic enter(input int ph);
        m_phase = ph;
        m_t     = 0;
    endtask

    task automatic model_edge(input logic r, input logic s, input logic l);
        logic lock_s;
        lock_s = m_s2;
        if (r) begin
            enter(PH_RESET);
            m_wait  = 0;
            m_retry = 0;
            m_loss  = 0;
            m_s1    = 1'b0;
            m_s2    = 1'b0;
            return;
        end
        m_s2 = m_s1;
        m_s1 = l;
        if (s) begin
            enter(PH_RESET);
            m_retry = 0;
        end else if ((m_phase == PH_RELEASE || m_phase == PH_RUN) && !lock_s) begin
            enter(PH_RESET);
            m_retry = 0;
            if (m_loss < 255) m_loss++;
        end else if ((m_phase == PH_WAIT || m_phase == PH_STABLE) && m_wait + 1 == P_TMO) begin
            m_retry++;
            enter((m_retry == P_RETRY) ? PH_FAULT : PH_RESET);
        end else if (m_phase == PH_RESET) begin
            if (m_t + 1 == P_PULSE) begin
                enter(PH_WAIT);
                m_wait = 0;
            end else m_t++;
        end else if (m_phase == PH_WAIT) begin
            m_wait++;
            if (lock_s) enter(PH_STABLE);
            else m_t++;
        end else if (m_phase == PH_STABLE) begin
            m_wait++;
            if (!lock_s) enter(PH_WAIT);
            else if (m_t + 1 == P_STABLE) enter(PH_RELEASE);
            else m_t++;
        end else if (m_phase == PH_RELEASE) begin
            if (m_t == (P_N - 1) * P_STG) begin
                enter(PH_RUN);
                m_retry = 0;
            end else m_t++;
        end
    endtask

    function automatic logic [16:0] model_out();
        logic [2:0] d;
        logic [7:0] lc;
        logic [2:0] ss;
        for (int i = 0; i < P_N; i++) begin
            if (m_phase == PH_RUN) d[i] = 1'b0;
            else if (m_phase == PH_RELEASE) d[i] = (m_t < i * P_STG);
            else d[i] = 1'b1;
        end
        lc = STATUS ? 8'(m_loss) : 8'd0;
        ss = STATUS ? 3'(m_phase) : 3'd0;
        return {m_phase == PH_RESET || m_phase == PH_FAULT, d, m_phase == PH_RUN,
                m_phase == PH_FAULT, lc, ss};
    endfunction

    task automatic tick();
        logic r, s, l;
        r = rst;
        s = sw;
        l = locked;
        @(posedge clk);
        model_edge(r, s, l);
        #1;
        cyc++;
        chk($sformatf("cycle%0d", cyc),
            {15'd0, pll_rst_o, domain_rst_o, ready_o, fault_o, lock_loss_cnt_o, seq_state_o},
            {15'd0, model_out()});
    endtask

    task automatic run_until_ready(input int budget, input string tag);
        int k;
        k = 0;
        while (ready_o !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, ready_o}, 32'd1);
    endtask

    initial begin
        int  n, npr, b0, b1, b2, rdy, e0, mode;
        bit  seen, ok;

        // 1. Reset then clean bring-up
        rst = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", {26'd0, pll_rst_o, domain_rst_o, ready_o, fault_o}, 32'h3C);
        rst = 1'b0;
        npr = pll_rst_o ? 1 : 0;
        b0 = -1; b1 = -1; b2 = -1; rdy = -1;
        for (int k = 0; k < 120 && ready_o !== 1'b1; k++) begin
            if (k == 10) locked = 1'b1;
            tick();
            npr += pll_rst_o ? 1 : 0;
            if (b0 < 0 && domain_rst_o[0] == 1'b0) b0 = cyc;
            if (b1 < 0 && domain_rst_o[1] == 1'b0) b1 = cyc;
            if (b2 < 0 && domain_rst_o[2] == 1'b0) b2 = cyc;
            if (ready_o === 1'b1) rdy = cyc;
        end
        chk("bringup_pll_rst_len", npr, 4);
        chk("bringup_stagger01", b1 - b0, 2);
        chk("bringup_stagger12", b2 - b1, 2);
        chk("bringup_ready_after_d2", rdy - b2, 1);
        repeat (5) tick();

        // 2. Glitchy lock restarts the stability count
        sw = 1'b1; locked = 1'b0;
        tick();
        sw = 1'b0;
        repeat (6) tick();
        locked = 1'b1;
        repeat (5) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        tick();
        e0 = cyc;
        run_until_ready(60, "glitch_ready");
        chk("glitch_ready_latency", cyc - e0, 15);

        // 3. Lock never arrives: retries then fault, cleared by sw_reset_req
        sw = 1'b1; locked = 1'b0;
        tick();
        sw = 1'b0;
        n = 1; npr = 0;
        while (fault_o !== 1'b1 && n < 200) begin
            npr += pll_rst_o ? 1 : 0;
            tick();
            n++;
        end
        chk("timeout_fault_latency", n, 73);
        chk("timeout_pll_rst_cycles", npr, 8);
        repeat (10) tick();
        chk("fault_sticky", {30'd0, fault_o, pll_rst_o}, 32'd3);
        sw = 1'b1;
        tick();
        sw = 1'b0;
        chk("fault_cleared", {31'd0, fault_o}, 32'd0);
        locked = 1'b1;
        run_until_ready(80, "after_fault_ready");

        // 4. One-cycle lock drop in RUN
        repeat (3) tick();
        locked = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            locked = 1'b1;
            if (domain_rst_o == 3'b111 && ready_o == 1'b0) seen = 1'b1;
        end
        chk("lockloss_reaction", {31'd0, seen}, 32'd1);
        chk("lockloss_count", {24'd0, lock_loss_cnt_o}, STATUS ? 32'd1 : 32'd0);
        run_until_ready(80, "lockloss_reseq_ready");

        // 5. Reset while domains are being released
        sw = 1'b1;
        tick();
        sw = 1'b0;
        n = 0;
        while (domain_rst_o[0] !== 1'b0 && n < 80) begin
            tick();
            n++;
        end
        chk("release_reached", {31'd0, domain_rst_o[0]}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_release", {25'd0, domain_rst_o, pll_rst_o, seq_state_o}, 32'h78);

        // 6. Many forced lock losses saturate the status counter
        ok = 1'b1;
        for (int j = 0; j < 300; j++) begin
            n = 0;
            while (domain_rst_o[0] !== 1'b0 && n < 80) begin
                tick();
                n++;
            end
            if (domain_rst_o[0] !== 1'b0) ok = 1'b0;
            repeat ($urandom_range(0, 6)) tick();
            locked = 1'b0;
            tick();
            locked = 1'b1;
            repeat (3) tick();
        end
        chk("loss_loop_progress", {31'd0, ok}, 32'd1);
        chk("loss_saturate", {24'd0, lock_loss_cnt_o}, STATUS ? 32'd255 : 32'd0);

        // 7. Random lock behaviour with occasional software and board resets
        for (int seg = 0; seg < 40; seg++) begin
            mode = int'($urandom_range(0, 3));
            for (int k = 0; k < 50; k++) begin
                if (mode == 0) locked = 1'b0;
                else if (mode == 1) locked = 1'b1;
                else locked = ($urandom_range(0, 15) != 0);
                sw  = ($urandom_range(0, 149) == 0);
                rst = ($urandom_range(0, 599) == 0);
                tick();
            end
        end
        rst = 1'b0;
        sw  = 1'b0;
        locked = 1'b1;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
